// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: default widths, fetch FSM states, control opcodes.
package mips_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int PC_INC_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;

   function automatic logic is_ctrl_op(input logic [5:0] op);
      return (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: sequential, branch, jump, plus the misaligned-redirect flag.
// Zero latency; no handshake of its own.
module pc_target_calc
   import mips_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int PC_INC = PC_INC_DEF
) (
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              br_taken_i,
   input  logic [15:0]       br_imm_i,
   input  logic              jmp_i,
   input  logic [25:0]       jmp_target_i,
   output logic [ADDR_W-1:0] seq_o,
   output logic [ADDR_W-1:0] redir_tgt_o,
   output logic              redir_o,
   output logic              misalign_o
);

   logic [ADDR_W-1:0] seq;
   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] br_tgt;
   logic [ADDR_W-1:0] jmp_tgt;

   assign seq     = pc_i + ADDR_W'(PC_INC);
   assign br_off  = {{(ADDR_W-18){br_imm_i[15]}}, br_imm_i, 2'b00};
   assign br_tgt  = seq + br_off;
   // Jumps stay inside the 256 MB region of the delay-slot address.
   assign jmp_tgt = {seq[ADDR_W-1:28], jmp_target_i, 2'b00};

   assign seq_o       = seq;
   assign redir_o     = jmp_i | br_taken_i;
   assign redir_tgt_o = jmp_i ? jmp_tgt : br_tgt;
   assign misalign_o  = redir_o & is_misaligned(redir_tgt_o[1:0]);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Architectural PC with valid/ready fetch handshake; pc updates the cycle after fire, pc held while stalled.
// DELAY_SLOT_EN defined: redirects take effect after one delay-slot fetch via a pending-target register.
module pc_fetch_sequencer
   import mips_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_INC   = PC_INC_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] pc,
   output logic              pc_valid,
   input  logic              pc_ready,
   input  logic              br_taken,
   input  logic [15:0]       br_imm,
   input  logic              jmp,
   input  logic [25:0]       jmp_target,
   input  logic              halt,
   input  logic              resume,
   output logic              addr_err,
   output logic [31:0]       instr_count
);

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              pc_valid_q;
   logic              addr_err_q;
   logic [31:0]       cnt_q, cnt_d;

   logic              fire;
   logic              redir;
   logic              misalign;
   logic              err_d;
   logic [ADDR_W-1:0] seq;
   logic [ADDR_W-1:0] redir_tgt;

   pc_target_calc #(
      .ADDR_W (ADDR_W),
      .PC_INC (PC_INC)
   ) u_target_calc (
      .pc_i         (pc_q),
      .br_taken_i   (br_taken),
      .br_imm_i     (br_imm),
      .jmp_i        (jmp),
      .jmp_target_i (jmp_target),
      .seq_o        (seq),
      .redir_tgt_o  (redir_tgt),
      .redir_o      (redir),
      .misalign_o   (misalign)
   );

   assign fire  = pc_valid_q & pc_ready;
   assign cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

`ifdef DELAY_SLOT_EN
   logic              pend_vld_q, pend_vld_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

   // Values below assume a fire this cycle; the state register only samples them on fire.
   always_comb begin
      pc_d       = seq;
      err_d      = 1'b0;
      pend_vld_d = pend_vld_q;
      pend_pc_d  = pend_pc_q;
      if (pend_vld_q) begin
         pc_d       = pend_pc_q;
         pend_vld_d = 1'b0;
      end else if (misalign) begin
         pc_d  = redir_tgt;
         err_d = 1'b1;
      end else if (redir) begin
         pend_vld_d = 1'b1;
         pend_pc_d  = redir_tgt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_vld_q <= 1'b0;
         pend_pc_q  <= '0;
      end else if (fire) begin
         pend_vld_q <= pend_vld_d;
         pend_pc_q  <= pend_pc_d;
      end
   end
`else
   always_comb begin
      pc_d  = seq;
      err_d = 1'b0;
      if (redir) begin
         pc_d  = redir_tgt;
         err_d = misalign;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         pc_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q    <= ST_RUN;
               pc_valid_q <= 1'b1;
            end
            ST_RUN: begin
               if (fire) begin
                  pc_q  <= pc_d;
                  cnt_q <= cnt_d;
                  if (err_d) begin
                     addr_err_q <= 1'b1;
                  end
                  if (err_d || halt) begin
                     state_q    <= ST_HALT;
                     pc_valid_q <= 1'b0;
                  end
               end
            end
            ST_HALT: begin
               // A misaligned redirect parks the sequencer until reset.
               if (resume && !addr_err_q) begin
                  state_q    <= ST_RUN;
                  pc_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               pc_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign pc          = pc_q;
   assign pc_valid    = pc_valid_q;
   assign addr_err    = addr_err_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: main instance plus two instances with non-zero reset PCs.
module tb_pc_fetch_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;

   logic        pc_ready, br_taken, jmp, halt, resume;
   logic [15:0] br_imm;
   logic [25:0] jmp_target;
   logic [31:0] a_pc, a_cnt;
   logic        a_vld, a_err;

   logic        b_rdy, b_jmp;
   logic [25:0] b_jt;
   logic [31:0] b_pc, b_cnt;
   logic        b_vld, b_err;

   logic        c_rdy, c_br, c_resume;
   logic [15:0] c_imm;
   logic [31:0] c_pc, c_cnt;
   logic        c_vld, c_err;

   int          compared = 0;
   int          mismatched = 0;
   logic [31:0] exp_cnt;

   pc_fetch_sequencer dut_a (
      .clk (clk), .rst_n (rst_n), .pc (a_pc), .pc_valid (a_vld), .pc_ready (pc_ready),
      .br_taken (br_taken), .br_imm (br_imm), .jmp (jmp), .jmp_target (jmp_target),
      .halt (halt), .resume (resume), .addr_err (a_err), .instr_count (a_cnt)
   );

   pc_fetch_sequencer #(.RESET_PC (32'h4000_0020)) dut_b (
      .clk (clk), .rst_n (rst_n), .pc (b_pc), .pc_valid (b_vld), .pc_ready (b_rdy),
      .br_taken (1'b0), .br_imm (16'h0000), .jmp (b_jmp), .jmp_target (b_jt),
      .halt (1'b0), .resume (1'b0), .addr_err (b_err), .instr_count (b_cnt)
   );

   pc_fetch_sequencer #(.RESET_PC (32'h0000_0002)) dut_c (
      .clk (clk), .rst_n (rst_n), .pc (c_pc), .pc_valid (c_vld), .pc_ready (c_rdy),
      .br_taken (c_br), .br_imm (c_imm), .jmp (1'b0), .jmp_target (26'h0),
      .halt (1'b0), .resume (c_resume), .addr_err (c_err), .instr_count (c_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fire_seq(input string tag, input logic [31:0] exp_pc);
      step();
      exp_cnt = exp_cnt + 32'd1;
      chk({tag, "_pc"}, a_pc, exp_pc);
      chk({tag, "_cnt"}, a_cnt, exp_cnt);
   endtask

   task automatic fire_redir(input string tag, input logic [31:0] seq_pc, input logic [31:0] tgt_pc);
`ifdef DELAY_SLOT_EN
      step();
      exp_cnt = exp_cnt + 32'd1;
      chk({tag, "_slot_pc"}, a_pc, seq_pc);
`else
      if (seq_pc == tgt_pc) $display("note: %s redirect equals sequential", tag);
`endif
      step();
      exp_cnt = exp_cnt + 32'd1;
      chk({tag, "_pc"}, a_pc, tgt_pc);
      chk({tag, "_cnt"}, a_cnt, exp_cnt);
   endtask

   initial begin
      rst_n = 1'b0;
      pc_ready = 1'b1; br_taken = 1'b0; br_imm = '0; jmp = 1'b0; jmp_target = '0;
      halt = 1'b0; resume = 1'b0;
      b_rdy = 1'b0; b_jmp = 1'b0; b_jt = '0;
      c_rdy = 1'b0; c_br = 1'b0; c_imm = '0; c_resume = 1'b0;
      exp_cnt = '0;

      #12;
      chk("rst_pc", a_pc, 32'h0);
      chk1("rst_vld", a_vld, 1'b0);
      chk("rst_cnt", a_cnt, 32'h0);
      chk1("rst_err", a_err, 1'b0);
      rst_n = 1'b1;

      // IDLE -> RUN: first clock after release presents pc without firing
      step();
      chk1("idle_vld", a_vld, 1'b1);
      chk("idle_pc", a_pc, 32'h0);
      chk("idle_cnt", a_cnt, 32'h0);
      fire_seq("seq1", 32'h4);
      fire_seq("seq2", 32'h8);
      fire_seq("seq3", 32'hC);
      fire_seq("seq4", 32'h10);

      br_taken = 1'b1; br_imm = 16'hFFFC;
      fire_redir("br_back", 32'h14, 32'h04);
      br_imm = 16'h0002;
      fire_redir("br_fwd1", 32'h08, 32'h10);
      fire_redir("br_fwd2", 32'h14, 32'h1C);

      // Jump beats branch when both are asserted
      jmp = 1'b1; jmp_target = 26'h000_0040; br_imm = 16'h0010;
      fire_redir("jmp_wins", 32'h20, 32'h100);
      jmp = 1'b0; br_taken = 1'b0;

      pc_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         br_taken = ~br_taken;
         step();
         chk("stall_pc", a_pc, 32'h100);
         chk("stall_cnt", a_cnt, exp_cnt);
         chk1("stall_vld", a_vld, 1'b1);
      end
      pc_ready = 1'b1; br_taken = 1'b1; br_imm = 16'hFFBE;
      fire_redir("br_top", 32'h104, 32'hFFFF_FFFC);
      br_taken = 1'b0;
      fire_seq("wrap", 32'h0);

      br_taken = 1'b1; br_imm = 16'h0007;
      fire_redir("br_20", 32'h4, 32'h20);
      br_taken = 1'b0;

      pc_ready = 1'b0; halt = 1'b1; resume = 1'b1;
      step();
      chk1("halt_nofire_vld", a_vld, 1'b1);
      chk("halt_nofire_pc", a_pc, 32'h20);
      resume = 1'b0; pc_ready = 1'b1;
      step();
      exp_cnt = exp_cnt + 32'd1;
      chk1("halt_vld", a_vld, 1'b0);
      chk("halt_pc", a_pc, 32'h24);
      chk("halt_cnt", a_cnt, exp_cnt);
      halt = 1'b0;
      step();
      chk1("halted_vld", a_vld, 1'b0);
      chk("halted_pc", a_pc, 32'h24);
      chk("halted_cnt", a_cnt, exp_cnt);
      resume = 1'b1;
      step();
      resume = 1'b0;
      chk1("resume_vld", a_vld, 1'b1);
      chk("resume_pc", a_pc, 32'h24);
      fire_seq("after_resume", 32'h28);

      br_taken = 1'b1; br_imm = 16'hFFF9;
      fire_redir("br_10", 32'h2C, 32'h10);
      br_imm = 16'h000B;
      fire_redir("br_40", 32'h14, 32'h40);
      br_taken = 1'b0; pc_ready = 1'b0;

      chk("b_hold_pc", b_pc, 32'h4000_0020);
      b_rdy = 1'b1; b_jmp = 1'b1; b_jt = 26'h000_0100;
      step();
`ifdef DELAY_SLOT_EN
      chk("b_slot_pc", b_pc, 32'h4000_0024);
      step();
`endif
      chk("b_jmp_pc", b_pc, 32'h4000_0400);
      b_rdy = 1'b0; b_jmp = 1'b0;

      chk("c_hold_pc", c_pc, 32'h2);
      c_rdy = 1'b1;
      step();
      chk("c_seq_pc", c_pc, 32'h6);
      chk1("c_seq_err", c_err, 1'b0);
      c_br = 1'b1; c_imm = 16'h0000;
      step();
      c_br = 1'b0;
      chk("c_mis_pc", c_pc, 32'hA);
      chk1("c_mis_err", c_err, 1'b1);
      chk1("c_mis_vld", c_vld, 1'b0);
      chk("c_mis_cnt", c_cnt, 32'h2);
      c_resume = 1'b1;
      step();
      c_resume = 1'b0;
      step();
      chk1("c_resume_vld", c_vld, 1'b0);
      chk1("c_resume_err", c_err, 1'b1);

      // Asynchronous reset while the main instance is stalled with a live request
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pc", a_pc, 32'h0);
      chk1("arst_vld", a_vld, 1'b0);
      chk("arst_cnt", a_cnt, 32'h0);
      chk1("arst_c_err", c_err, 1'b0);
      chk("arst_b_pc", b_pc, 32'h4000_0020);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
